// File: rtl/encode_reg_arith.sv
// RV32I register-register arithmetic encoder with an output FIFO.
// Optional pop counter port enabled by defining ENCODE_REG_ARITH_COUNT_EN.

package encode_reg_arith_pkg;
   typedef enum logic [3:0] {
      rak_invalid = 4'd0,
      rak_add     = 4'd1,
      rak_sub     = 4'd2,
      rak_sll     = 4'd3,
      rak_slt     = 4'd4,
      rak_sltu    = 4'd5,
      rak_xor     = 4'd6,
      rak_srl     = 4'd7,
      rak_sra     = 4'd8,
      rak_or      = 4'd9,
      rak_and     = 4'd10
   } reg_arith_kind_t;
endpackage

module encode_reg_arith
   import encode_reg_arith_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  reg_arith_kind_t in_kind,
   input  logic [4:0]      in_rd,
   input  logic [4:0]      in_rs1,
   input  logic [4:0]      in_rs2,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [31:0]     out_instr,
   output logic            err_invalid
`ifdef ENCODE_REG_ARITH_COUNT_EN
   ,
   output logic [31:0]     count
`endif
);

   localparam int              PTR_W   = $clog2(DEPTH);
   localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
   localparam logic [PTR_W:0]   OCC_ONE = (PTR_W + 1)'(1);
   localparam logic [PTR_W:0]   OCC_MAX = (PTR_W + 1)'(DEPTH);
   localparam logic [6:0]       OPCODE  = 7'b0110011;

   logic [31:0]      mem_r [DEPTH];
   logic [PTR_W-1:0] wr_ptr_r;
   logic [PTR_W-1:0] rd_ptr_r;
   logic [PTR_W:0]   occ_r;
   logic             in_ready_r;
   logic             out_valid_r;
   logic [31:0]      out_instr_r;
   logic             err_r;

   logic             kind_ok_s;
   logic [6:0]       funct7_s;
   logic [2:0]       funct3_s;
   logic [31:0]      enc_s;
   logic             accept_s;
   logic             push_s;
   logic             pop_s;
   logic [PTR_W-1:0] wr_ptr_nxt_s;
   logic [PTR_W-1:0] rd_ptr_nxt_s;
   logic [PTR_W:0]   occ_nxt_s;
   logic [31:0]      head_nxt_s;

   // Kind to funct7/funct3 lookup and R-type word assembly
   always_comb begin
      kind_ok_s = 1'b1;
      funct7_s  = 7'b0000000;
      funct3_s  = 3'b000;
      case (in_kind)
         rak_add:  begin funct7_s = 7'b0000000; funct3_s = 3'b000; end
         rak_sub:  begin funct7_s = 7'b0100000; funct3_s = 3'b000; end
         rak_sll:  begin funct7_s = 7'b0000000; funct3_s = 3'b001; end
         rak_slt:  begin funct7_s = 7'b0000000; funct3_s = 3'b010; end
         rak_sltu: begin funct7_s = 7'b0000000; funct3_s = 3'b011; end
         rak_xor:  begin funct7_s = 7'b0000000; funct3_s = 3'b100; end
         rak_srl:  begin funct7_s = 7'b0000000; funct3_s = 3'b101; end
         rak_sra:  begin funct7_s = 7'b0100000; funct3_s = 3'b101; end
         rak_or:   begin funct7_s = 7'b0000000; funct3_s = 3'b110; end
         rak_and:  begin funct7_s = 7'b0000000; funct3_s = 3'b111; end
         default:  kind_ok_s = 1'b0;
      endcase
      enc_s = {funct7_s, in_rs2, in_rs1, funct3_s, in_rd, OPCODE};
   end

   // FIFO next-state: pointers, occupancy and the word that will sit at the head
   always_comb begin
      accept_s = in_valid && in_ready_r;
      push_s   = accept_s && kind_ok_s;
      pop_s    = out_valid_r && out_ready;

      if (push_s) begin
         wr_ptr_nxt_s = wr_ptr_r + PTR_ONE;
      end else begin
         wr_ptr_nxt_s = wr_ptr_r;
      end

      if (pop_s) begin
         rd_ptr_nxt_s = rd_ptr_r + PTR_ONE;
      end else begin
         rd_ptr_nxt_s = rd_ptr_r;
      end

      case ({push_s, pop_s})
         2'b10:   occ_nxt_s = occ_r + OCC_ONE;
         2'b01:   occ_nxt_s = occ_r - OCC_ONE;
         default: occ_nxt_s = occ_r;
      endcase

      // The new head is the word being written now when it lands on the read slot
      if (occ_nxt_s == '0) begin
         head_nxt_s = 32'h0000_0000;
      end else if (push_s && (rd_ptr_nxt_s == wr_ptr_r)) begin
         head_nxt_s = enc_s;
      end else begin
         head_nxt_s = mem_r[rd_ptr_nxt_s];
      end
   end

   // Storage array; contents need no reset because occupancy guards every read
   always_ff @(posedge clk) begin
      if (push_s) begin
         mem_r[wr_ptr_r] <= enc_s;
      end
   end

   // Control state and registered handshake/data outputs
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_r    <= '0;
         rd_ptr_r    <= '0;
         occ_r       <= '0;
         in_ready_r  <= 1'b1;
         out_valid_r <= 1'b0;
         out_instr_r <= 32'h0000_0000;
         err_r       <= 1'b0;
      end else begin
         wr_ptr_r    <= wr_ptr_nxt_s;
         rd_ptr_r    <= rd_ptr_nxt_s;
         occ_r       <= occ_nxt_s;
         in_ready_r  <= (occ_nxt_s < OCC_MAX);
         out_valid_r <= (occ_nxt_s != '0);
         out_instr_r <= head_nxt_s;
         err_r       <= accept_s && !kind_ok_s;
      end
   end

   assign in_ready    = in_ready_r;
   assign out_valid   = out_valid_r;
   assign out_instr   = out_instr_r;
   assign err_invalid = err_r;

`ifdef ENCODE_REG_ARITH_COUNT_EN
   logic [31:0] count_r;

   // Popped-word counter, wraps naturally at 32 bits
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count_r <= 32'h0000_0000;
      end else if (pop_s) begin
         count_r <= count_r + 32'd1;
      end else begin
         count_r <= count_r;
      end
   end

   assign count = count_r;
`endif

endmodule

// File: tb/tb_encode_reg_arith.sv
// Testbench for encode_reg_arith: vector table plus scoreboard-checked corner sequences.
module tb_encode_reg_arith;
   import encode_reg_arith_pkg::*;

   localparam int DEPTH = 2;

   typedef struct {
      reg_arith_kind_t kind;
      logic [4:0]      rd;
      logic [4:0]      rs1;
      logic [4:0]      rs2;
      logic [31:0]     exp;
   } vec_t;

   logic            clk = 1'b0;
   logic            rst;
   logic            in_valid;
   logic            in_ready;
   reg_arith_kind_t in_kind;
   logic [4:0]      in_rd;
   logic [4:0]      in_rs1;
   logic [4:0]      in_rs2;
   logic            out_valid;
   logic            out_ready;
   logic [31:0]     out_instr;
   logic            err_invalid;
`ifdef ENCODE_REG_ARITH_COUNT_EN
   logic [31:0]     count;
`endif

   int          n_checks = 0;
   int          n_fail   = 0;
   logic [31:0] cur_exp;
   logic [31:0] sb_q[$];
   logic        err_exp;
   vec_t        vecs[14];

   encode_reg_arith #(.DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_kind(in_kind),
      .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
      .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
      .err_invalid(err_invalid)
`ifdef ENCODE_REG_ARITH_COUNT_EN
      , .count(count)
`endif
   );

   always #5 clk = ~clk;

   function automatic vec_t mk(reg_arith_kind_t k, logic [6:0] f7, logic [2:0] f3,
                               logic [4:0] rd, logic [4:0] rs1, logic [4:0] rs2);
      vec_t v;
      v.kind = k; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2;
      v.exp  = {f7, rs2, rs1, f3, rd, 7'b0110011};
      return v;
   endfunction

   function automatic logic kind_ok(reg_arith_kind_t k);
      return (k >= rak_add) && (k <= rak_and);
   endfunction

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Scoreboard/monitor step, called once per negedge
   task automatic monitor_step();
      logic accept;
      logic [31:0] e;
      if (!rst) begin
         sb_q.delete();
         err_exp = 1'b0;
      end else begin
         chk("mon_out_valid", out_valid, sb_q.size() != 0);
         chk("mon_in_ready", in_ready, sb_q.size() < DEPTH);
         chk("mon_err_invalid", err_invalid, err_exp);
         if (!out_valid) chk("mon_instr_idle_zero", out_instr, 32'h0);
         accept  = in_valid && in_ready;
         err_exp = accept && !kind_ok(in_kind);
         if (out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
               chk("mon_unexpected_pop", 32'd1, 32'd0);
            end else begin
               e = sb_q.pop_front();
               chk("mon_pop_word", out_instr, e);
            end
         end
         if (accept && kind_ok(in_kind)) sb_q.push_back(cur_exp);
      end
   endtask

   // Drive one request (entered and left at posedge+1), bounded wait for acceptance
   task automatic send(vec_t v);
      logic acc = 1'b0;
      in_valid = 1'b1; in_kind = v.kind; in_rd = v.rd; in_rs1 = v.rs1; in_rs2 = v.rs2;
      cur_exp  = v.exp;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (in_ready) begin
            acc = 1'b1;
            break;
         end
         @(posedge clk); #1;
      end
      if (!acc) chk("send_timeout", 32'd0, 32'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic wait_drain();
      logic done = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk); #2;
         if (sb_q.size() == 0 && !out_valid) begin
            done = 1'b1;
            break;
         end
      end
      if (!done) chk("drain_timeout", 32'd0, 32'd1);
      @(posedge clk); #1;
   endtask

   initial begin
`ifdef ENCODE_REG_ARITH_COUNT_EN
      logic [31:0] cnt_before;
`endif
      vecs[0]  = '{rak_add, 5'd3, 5'd1, 5'd2, 32'h002081B3};
      vecs[1]  = '{rak_sub, 5'd5, 5'd6, 5'd7, 32'h407302B3};
      vecs[2]  = '{rak_sra, 5'd10, 5'd11, 5'd12, 32'h40C5D533};
      vecs[3]  = mk(rak_sll,  7'b0000000, 3'b001, 5'd1,  5'd2,  5'd3);
      vecs[4]  = mk(rak_slt,  7'b0000000, 3'b010, 5'd4,  5'd5,  5'd6);
      vecs[5]  = mk(rak_sltu, 7'b0000000, 3'b011, 5'd7,  5'd8,  5'd9);
      vecs[6]  = mk(rak_xor,  7'b0000000, 3'b100, 5'd31, 5'd30, 5'd29);
      vecs[7]  = '{rak_invalid, 5'd1, 5'd1, 5'd1, 32'h0};
      vecs[8]  = '{reg_arith_kind_t'(4'd13), 5'd2, 5'd2, 5'd2, 32'h0};
      vecs[9]  = mk(rak_srl,  7'b0000000, 3'b101, 5'd15, 5'd16, 5'd17);
      vecs[10] = mk(rak_or,   7'b0000000, 3'b110, 5'd0,  5'd31, 5'd1);
      vecs[11] = mk(rak_and,  7'b0000000, 3'b111, 5'd20, 5'd21, 5'd22);
      vecs[12] = mk(rak_add,  7'b0000000, 3'b000, 5'd31, 5'd31, 5'd31);
      vecs[13] = mk(rak_sub,  7'b0100000, 3'b000, 5'd0,  5'd0,  5'd0);

      rst = 1'b0; in_valid = 1'b0; in_kind = rak_invalid;
      in_rd = 5'd0; in_rs1 = 5'd0; in_rs2 = 5'd0; out_ready = 1'b0;
      cur_exp = 32'h0; err_exp = 1'b0;

      fork
         forever begin
            @(negedge clk);
            monitor_step();
         end
      join_none

      #12;
      chk("rst_in_ready", in_ready, 32'd1);
      chk("rst_out_valid", out_valid, 32'd0);
      chk("rst_out_instr", out_instr, 32'h0);
      chk("rst_err_invalid", err_invalid, 32'd0);
`ifdef ENCODE_REG_ARITH_COUNT_EN
      chk("rst_count", count, 32'd0);
`endif
      @(posedge clk); #1;
      rst = 1'b1;
      out_ready = 1'b1;

      // Single-cycle latency on the reference add
      send(vecs[0]);
      @(negedge clk);
      chk("lat_out_valid", out_valid, 32'd1);
      chk("lat_out_instr", out_instr, 32'h002081B3);
      wait_drain();

      // Whole vector table back to back, consumer always ready
      foreach (vecs[i]) send(vecs[i]);
      wait_drain();

      // Lone invalid request
`ifdef ENCODE_REG_ARITH_COUNT_EN
      cnt_before = count;
`endif
      send(vecs[7]);
      @(negedge clk);
      chk("inv_err_high", err_invalid, 32'd1);
      chk("inv_out_valid", out_valid, 32'd0);
      @(negedge clk);
      chk("inv_err_low", err_invalid, 32'd0);
`ifdef ENCODE_REG_ARITH_COUNT_EN
      chk("inv_count_same", count, cnt_before);
`endif
      @(posedge clk); #1;

      // Backpressure: two fill the FIFO, the third waits for a pop
      out_ready = 1'b0;
      send(vecs[1]);
      send(vecs[2]);
      in_valid = 1'b1; in_kind = vecs[3].kind; in_rd = vecs[3].rd;
      in_rs1 = vecs[3].rs1; in_rs2 = vecs[3].rs2; cur_exp = vecs[3].exp;
      @(negedge clk);
      chk("full_in_ready", in_ready, 32'd0);
      @(posedge clk); #1;
      out_ready = 1'b1;
      @(negedge clk);
      chk("full_pop_in_ready", in_ready, 32'd0);
      chk("full_head", out_instr, 32'h407302B3);
      @(posedge clk); #1;
      @(negedge clk);
      chk("freed_in_ready", in_ready, 32'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      wait_drain();

      // Asynchronous reset with two words queued
      out_ready = 1'b0;
      send(vecs[4]);
      send(vecs[5]);
      #2;
      rst = 1'b0;
      #1;
      chk("arst_out_valid", out_valid, 32'd0);
      chk("arst_in_ready", in_ready, 32'd1);
      chk("arst_out_instr", out_instr, 32'h0);
      @(posedge clk); #1;
      rst = 1'b1;
      out_ready = 1'b1;
`ifdef ENCODE_REG_ARITH_COUNT_EN
      chk("arst_count", count, 32'd0);
      for (int i = 3; i < 8; i++) send(vecs[i == 7 ? 9 : i]);
      wait_drain();
      chk("count_five", count, 32'd5);
      force dut.count_r = 32'hFFFF_FFFF;
      #1;
      release dut.count_r;
      send(vecs[10]);
      wait_drain();
      chk("count_wrap", count, 32'd0);
`else
      send(vecs[6]);
      @(negedge clk);
      chk("post_rst_word", out_instr, vecs[6].exp);
      wait_drain();
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
